// File: rtl/sym_tap_pair_sum_pkg.sv
// Shared helpers for the symmetric tap-pair pre-adder and the MAC stages behind it:
// index widths and the halving rounder.
package sym_tap_pair_sum_pkg;

   // Widest pre-added sum the rounder accepts; callers sign-extend into it.
   localparam int RH_W = 64;

   function automatic int chan_w(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

   function automatic int pair_w(input int taps);
      return $clog2((taps - 1) / 2 + 1);
   endfunction

   // Halves a sign-extended sum; with rnd set, exact .5 results go to the even neighbour.
   function automatic logic signed [RH_W-1:0] round_half(input logic signed [RH_W:0] s,
                                                         input logic              rnd);
      logic signed [RH_W-1:0] q;
      q = s[RH_W:1];
      if (rnd) begin
         q = q + RH_W'(s[1] & s[0]);
      end
      return q;
   endfunction

endpackage

// File: rtl/sym_tap_pair_sum_if.sv
// Sample-in / pair-sum-out bundle of the tap-pair pre-adder.
interface sym_tap_pair_sum_if
   import sym_tap_pair_sum_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int TAPS     = 11,
   parameter int CHANNELS = 2
);
   localparam int CW = chan_w(CHANNELS);
   localparam int PW = pair_w(TAPS);

   logic                      strobe_in;
   logic [CHANNELS*WIDTH-1:0] data_in;
   logic                      busy;
   logic                      sum_valid;
   logic [WIDTH-1:0]          sum_out;
   logic [CW-1:0]             sum_chan;
   logic [PW-1:0]             sum_pair;
   logic                      sum_last;
   logic                      overrun;

   modport master (
      output strobe_in, data_in,
      input  busy, sum_valid, sum_out, sum_chan, sum_pair, sum_last, overrun
   );

   modport slave (
      input  strobe_in, data_in,
      output busy, sum_valid, sum_out, sum_chan, sum_pair, sum_last, overrun
   );

endinterface

// File: rtl/sym_tap_ram.sv
// One channel's circular delay line: single write port, two registered read ports whose
// outputs are forced to zero for taps that have not been written since reset.
module sym_tap_ram #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clock,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic [AW-1:0]    rd_addr_a_i,
   input  logic [AW-1:0]    rd_addr_b_i,
   input  logic             zero_a_i,
   input  logic             zero_b_i,
   output logic [WIDTH-1:0] rd_data_a_o,
   output logic [WIDTH-1:0] rd_data_b_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_a_q;
   logic [WIDTH-1:0] rd_b_q;

   always_ff @(posedge clock) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Masking in the output register keeps uninitialised entries out of the sums.
   always_ff @(posedge clock) begin
      rd_a_q <= zero_a_i ? '0 : mem_q[rd_addr_a_i];
      rd_b_q <= zero_b_i ? '0 : mem_q[rd_addr_b_i];
   end

   assign rd_data_a_o = rd_a_q;
   assign rd_data_b_o = rd_b_q;

endmodule

// File: rtl/sym_tap_pair_sum.sv
// Multi-channel symmetric-FIR pre-adder: stores one sample per channel per strobe, then
// emits the rounded half-sum of every mirrored tap pair and the centre tap.
module sym_tap_pair_sum
   import sym_tap_pair_sum_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 16,
   parameter int TAPS     = 11,
   parameter int CHANNELS = 2,
   parameter int ROUND    = 1
) (
   input logic               clock,
   input logic               reset,
   sym_tap_pair_sum_if.slave bus
);
   localparam int PAIRS = (TAPS - 1) / 2;
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = chan_w(CHANNELS);
   localparam int PW    = pair_w(TAPS);
   localparam int FW    = $clog2(TAPS + 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [AW-1:0]    wp_q, wp_d;
   logic [FW-1:0]    fill_q, fill_d;
   logic [CW-1:0]    ichan_q, ichan_d;
   logic [PW-1:0]    ipair_q, ipair_d;
   logic             busy_q, busy_d;
   logic             overrun_q, overrun_d;

   logic             s1_valid_q;
   logic             s1_last_q;
   logic [CW-1:0]    s1_chan_q;
   logic [PW-1:0]    s1_pair_q;

   logic             valid_q;
   logic             last_q;
   logic [CW-1:0]    chan_q;
   logic [PW-1:0]    pair_q;
   logic [WIDTH-1:0] sum_q, sum_d;

   logic             retire;
   logic             accept;
   logic             issuing;
   logic             issue_last;
   logic [FW-1:0]    tap_a, tap_b;
   logic [AW-1:0]    base_addr, rd_addr_a, rd_addr_b;
   logic             zero_a, zero_b;

   logic [WIDTH-1:0]        rd_a [CHANNELS];
   logic [WIDTH-1:0]        rd_b [CHANNELS];
   logic signed [WIDTH-1:0] op_a, op_b;
   logic signed [WIDTH:0]   pair_sum;

   // A strobe landing on the cycle the last item retires starts the next sequence.
   assign retire     = valid_q & last_q;
   assign accept     = bus.strobe_in & (~busy_q | retire);
   assign issuing    = (state_q == ST_RUN);
   assign issue_last = issuing && (ichan_q == CW'(CHANNELS - 1)) && (ipair_q == PW'(PAIRS));

   // wp already points one past the newest sample while the sequence runs.
   assign base_addr = wp_q - AW'(1);
   assign tap_a     = FW'(ipair_q);
   assign tap_b     = (ipair_q == PW'(PAIRS)) ? tap_a : FW'(TAPS - 1) - tap_a;
   assign rd_addr_a = base_addr - AW'(tap_a);
   assign rd_addr_b = base_addr - AW'(tap_b);
   assign zero_a    = (tap_a >= fill_q);
   assign zero_b    = (tap_b >= fill_q);

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      sym_tap_ram #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_ram (
         .clock       (clock),
         .wr_en_i     (accept),
         .wr_addr_i   (wp_q),
         .wr_data_i   (bus.data_in[gi*WIDTH +: WIDTH]),
         .rd_addr_a_i (rd_addr_a),
         .rd_addr_b_i (rd_addr_b),
         .zero_a_i    (zero_a),
         .zero_b_i    (zero_b),
         .rd_data_a_o (rd_a[gi]),
         .rd_data_b_o (rd_b[gi])
      );
   end

   always_comb begin
      state_d = state_q;
      ichan_d = ichan_q;
      ipair_d = ipair_q;
      if (issuing) begin
         if (ipair_q == PW'(PAIRS)) begin
            ipair_d = '0;
            ichan_d = ichan_q + CW'(1);
         end else begin
            ipair_d = ipair_q + PW'(1);
         end
         if (issue_last) begin
            state_d = ST_IDLE;
            ichan_d = '0;
         end
      end else if (accept) begin
         state_d = ST_RUN;
         ichan_d = '0;
         ipair_d = '0;
      end
   end

   always_comb begin
      wp_d      = accept ? wp_q + AW'(1) : wp_q;
      fill_d    = (accept && (fill_q != FW'(TAPS))) ? fill_q + FW'(1) : fill_q;
      busy_d    = accept ? 1'b1 : (retire ? 1'b0 : busy_q);
      overrun_d = overrun_q | (bus.strobe_in & ~accept);
   end

   // The sum of two WIDTH-bit values halved always fits back into WIDTH bits.
   assign op_a     = rd_a[s1_chan_q];
   assign op_b     = rd_b[s1_chan_q];
   assign pair_sum = {op_a[WIDTH-1], op_a} + {op_b[WIDTH-1], op_b};
   assign sum_d    = WIDTH'(round_half({{(RH_W - WIDTH){pair_sum[WIDTH]}}, pair_sum},
                                       ROUND != 0));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         wp_q       <= '0;
         fill_q     <= '0;
         ichan_q    <= '0;
         ipair_q    <= '0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_chan_q  <= '0;
         s1_pair_q  <= '0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         chan_q     <= '0;
         pair_q     <= '0;
         sum_q      <= '0;
      end else begin
         state_q    <= state_d;
         wp_q       <= wp_d;
         fill_q     <= fill_d;
         ichan_q    <= ichan_d;
         ipair_q    <= ipair_d;
         busy_q     <= busy_d;
         overrun_q  <= overrun_d;
         s1_valid_q <= issuing;
         s1_last_q  <= issue_last;
         s1_chan_q  <= ichan_q;
         s1_pair_q  <= ipair_q;
         valid_q    <= s1_valid_q;
         last_q     <= s1_valid_q & s1_last_q;
         if (s1_valid_q) begin
            chan_q <= s1_chan_q;
            pair_q <= s1_pair_q;
            sum_q  <= sum_d;
         end
      end
   end

   assign bus.busy      = busy_q;
   assign bus.sum_valid = valid_q;
   assign bus.sum_out   = sum_q;
   assign bus.sum_chan  = chan_q;
   assign bus.sum_pair  = pair_q;
   assign bus.sum_last  = last_q;
   assign bus.overrun   = overrun_q;

endmodule
